i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) endpoint with an internal 16 x 8 register file, the responding end of the team's I2C master on the same bus. It oversamples raw SCL/SDA on the system clock, detects START/STOP, matches a 7-bit device address and accepts register-address and write-data bytes. It returns read data with auto-incrementing register pointer and drives SDA open-drain through an output-enable. It sits behind the board I2C pins and exposes writes and a readback port to local logic.

## Interface
- DEV_ADDR, 7'h50, 7-bit device address answered with ACK
- REG_AW, 4, register index width; NUM_REGS = 2**REG_AW
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- scl_in  in  1  raw bus SCL (asynchronous)
- sda_in  in  1  raw bus SDA (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain)
- busy  out  1  high from START detect to STOP detect
- wr_strobe  out  1  one-cycle pulse per bus write byte stored
- wr_addr  out  REG_AW  register index of the stored byte
- wr_data  out  8  byte stored
- host_addr  in  REG_AW  local readback index
- host_rdata  out  8  register[host_addr], registered

## Operation
- Inputs pass 2-flop synchronizers; edges are taken on synced values vs. previous sample.
- START = synced SDA falls while synced SCL high. STOP = SDA rises while SCL high. Both are checked every cycle in every state and take priority over bit handling.
- Data is sampled on SCL rising edges, MSB first. sda_oe changes only on SCL falling edges, except on STOP, repeated START or reset, which release SDA.
- States: IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WRITE, ACK_WR, READ, MACK, IGNORE.
- IDLE: sda_oe=0. START -> DEV_ADDR, bit counter = 0.
- DEV_ADDR: shift 8 bits. On the 8th SCL fall:
  - byte[7:1]==DEV_ADDR: ACK_DEV, assert sda_oe.
  - otherwise: IGNORE, SDA released, until STOP or START.
- ACK_DEV: on the 9th SCL fall:
  - R/W=0: release SDA -> REG_ADDR.
  - R/W=1: load shift reg with reg[ptr], drive its MSB (sda_oe = ~bit) -> READ.
- REG_ADDR: 8 bits, then ACK (ACK_REG) with ptr <= byte[REG_AW-1:0]; upper bits are ignored. Then WRITE.
- WRITE: 8 bits -> on the 8th SCL rise:
  - store reg[ptr]; wr_strobe=1 for one cycle with wr_addr=ptr and wr_data=byte.
  - ACK_WR on the following fall; ptr <= ptr+1 mod NUM_REGS; back to WRITE after the 9th fall.
- READ: shift out 8 bits, one per SCL fall. After the 8th bit, release SDA -> MACK.
- MACK: sample SDA on the 9th SCL rise.
  - Low (ACK): ptr++ mod NUM_REGS, load next byte on the fall -> READ.
  - High (NACK): IGNORE.
- Repeated START in any state -> DEV_ADDR; ptr retained; shift/bit counters cleared.
- STOP in any state -> IDLE; ptr retained.
- A byte is committed only at its 8th rising edge; a partial byte cut off by START/STOP is discarded.
- No clock stretching. The target never drives SCL.

## Timing
- Reset values:
  - outputs: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, host_rdata=0.
  - internal: all registers 0, ptr=0, state IDLE.
- Reset mid-transfer releases SDA on the clock edge sampling rst=1.
- Raw pin edge -> internal event: 3 clk (2 sync + edge register).
- sda_oe is valid at most 3 clk after the raw SCL falling edge.
- Bus requirement: SCL high and low phases are each >= 4 clk; SDA changes from the master only while SCL is low, except START/STOP.
- wr_strobe asserts 3 clk after the raw 8th SCL rise of a write byte.
- host_rdata: 1-cycle latency from host_addr. A same-cycle bus write to that index is visible the cycle after the write.
- busy rises 3 clk after raw START and falls 3 clk after raw STOP.

## Test plan
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - ACK on all 4 bytes.
  - wr_strobe pulses at (3,0x11) and (4,0x22).
  - host_addr=4 -> host_rdata=0x22.
- Random read: preload reg[0xF]=0x5A and reg[0x0]=0xC3. START, 0xA0, 0x0F, repeated START, 0xA1.
  - Master ACKs byte 1 and NACKs byte 2, then STOP.
  - SDA carries 0x5A then 0xC3 (pointer wrap); SDA is released at NACK.
- Address mismatch: START, 0x42, 0x01, STOP.
  - sda_oe never asserts; no wr_strobe; busy toggles.
- Abort: START, 0xA0, 0x02, 4 bits of 0xFF, STOP.
  - No wr_strobe; reg[2] unchanged.
  - Next START, 0xA1 read returns reg[2].
- Reset mid-read: assert rst while the target drives 0 during READ.
  - sda_oe=0 next cycle; all outputs at reset values.
  - The following transfer is ACKed normally.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// i2c_target_regs_if: raw I2C pin bundle between the board bus and the target
interface i2c_target_regs_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  modport master (output scl_in, sda_in, input sda_oe);
  modport slave (input scl_in, sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target with a 16x8 register file and auto-incrementing pointer
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int REG_AW = 4
) (
  input  logic clk,
  input  logic rst,
  i2c_target_regs_if.slave bus,
  output logic busy,
  output logic wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0] host_rdata
);
  localparam int NUM_REGS = 2**REG_AW;
  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_REG_ADDR, ST_ACK_REG,
    ST_WRITE, ST_ACK_WR, ST_READ, ST_MACK, ST_IGNORE
  } state_t;
  state_t state, next;
  logic [1:0] scl_sync, sda_sync;
  logic scl_p, sda_p, scl_s, sda_s;
  logic scl_rise, scl_fall, start, stop, wr_en, shifting, oe;
  logic [3:0] cnt;
  logic [7:0] sh, byte_in;
  logic [REG_AW-1:0] ptr;
  logic [7:0] regs [NUM_REGS];
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop = scl_s & scl_p & ~sda_p & sda_s;
  assign byte_in = {sh[6:0], sda_s};
  assign shifting = state == ST_DEV_ADDR || state == ST_REG_ADDR || state == ST_WRITE;
  assign wr_en = state == ST_WRITE && scl_rise && cnt == 4'd7;
  assign busy = state != ST_IDLE;
  assign bus.sda_oe = oe;
  always_ff @(posedge clk) state <= rst ? ST_IDLE : next;
  always_comb begin
    next = state;
    if (start)
      next = ST_DEV_ADDR;
    else if (stop)
      next = ST_IDLE;
    else if (scl_rise && state == ST_MACK && sda_s)
      next = ST_IGNORE;
    else if (scl_fall)
      case (state)
        ST_DEV_ADDR: if (cnt == 4'd8) next = sh[7:1] == DEV_ADDR ? ST_ACK_DEV : ST_IGNORE;
        ST_ACK_DEV:  next = sh[0] ? ST_READ : ST_REG_ADDR;
        ST_REG_ADDR: if (cnt == 4'd8) next = ST_ACK_REG;
        ST_ACK_REG:  next = ST_WRITE;
        ST_WRITE:    if (cnt == 4'd8) next = ST_ACK_WR;
        ST_ACK_WR:   next = ST_WRITE;
        ST_READ:     if (cnt == 4'd7) next = ST_MACK;
        ST_MACK:     if (cnt == 4'd8) next = ST_READ;
        default:     next = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '0;
      sda_sync <= '0;
      scl_p <= 1'b0;
      sda_p <= 1'b0;
      cnt <= '0;
      sh <= '0;
      ptr <= '0;
      oe <= 1'b0;
      regs <= '{default: '0};
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      host_rdata <= '0;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_p <= scl_s;
      sda_p <= sda_s;
      wr_strobe <= wr_en;
      if (wr_en) begin
        regs[ptr] <= byte_in;
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
      // forward a same-cycle bus write so the host never sees the stale byte
      host_rdata <= wr_en && ptr == host_addr ? byte_in : regs[host_addr];
      if (start) begin
        cnt <= '0;
        sh <= '0;
        oe <= 1'b0;
      end else if (stop)
        oe <= 1'b0;
      else if (scl_rise && shifting) begin
        sh <= byte_in;
        cnt <= cnt + 1'b1;
      end else if (scl_rise && state == ST_MACK && !sda_s) begin
        ptr <= ptr + 1'b1;
        cnt <= 4'd8;
      end else if (scl_fall)
        case (state)
          ST_DEV_ADDR: if (cnt == 4'd8) oe <= sh[7:1] == DEV_ADDR;
          ST_ACK_DEV: begin
            cnt <= '0;
            sh <= regs[ptr];
            oe <= sh[0] & ~regs[ptr][7];
          end
          ST_REG_ADDR: if (cnt == 4'd8) begin
            oe <= 1'b1;
            ptr <= sh[REG_AW-1:0];
          end
          ST_ACK_REG, ST_ACK_WR: begin
            oe <= 1'b0;
            cnt <= '0;
          end
          ST_WRITE: if (cnt == 4'd8) begin
            oe <= 1'b1;
            ptr <= ptr + 1'b1;
          end
          ST_READ: if (cnt == 4'd7) oe <= 1'b0;
          else begin
            sh <= {sh[6:0], 1'b0};
            oe <= ~sh[6];
            cnt <= cnt + 1'b1;
          end
          ST_MACK: if (cnt == 4'd8) begin
            sh <= regs[ptr];
            oe <= ~regs[ptr][7];
            cnt <= '0;
          end
          default: oe <= 1'b0;
        endcase
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed write vectors plus read, abort and reset sequences
module tb_i2c_target_regs;
  typedef struct {
    logic [7:0] dev;
    logic [7:0] ra;
    logic [1:0][7:0] d;
    int n;
    logic ack;
  } wvec_t;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int lat;
  } st_t;
  localparam int NV = 6;
  logic clk = 0, rst = 1, m_scl = 1, m_sda = 1;
  logic busy, wr_strobe;
  logic [3:0] wr_addr, host_addr = '0;
  logic [7:0] wr_data, host_rdata;
  int n_chk = 0, n_bad = 0, cyc = 0, rise_cyc = 0;
  logic scl_prev = 1;
  bit any_oe = 0;
  st_t strobes [$];
  logic [7:0] model [16];
  wvec_t vt [NV];
  i2c_target_regs_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;
  i2c_target_regs dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .host_addr(host_addr), .host_rdata(host_rdata)
  );
  always #5 clk = ~clk;
  // rise seen at tick k: sync at k, k+1, strobe registered at k+2
  always @(posedge clk) begin
    #1;
    cyc++;
    if (m_scl && !scl_prev) rise_cyc = cyc;
    scl_prev = m_scl;
    if (bus.sda_oe) any_oe = 1;
    if (wr_strobe) strobes.push_back('{wr_addr, wr_data, cyc - rise_cyc});
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, output logic r);
    m_sda = b;
    tick(4);
    m_scl = 1;
    tick(4);
    r = bus.sda_in;
    tick(4);
    m_scl = 0;
    tick(4);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    ack = ~r;
  endtask
  task automatic read_byte(input logic mack, output logic [7:0] d, output logic line9);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, r);
      d = {d[6:0], r};
    end
    send_bit(~mack, line9);
  endtask
  task automatic i2c_start;
    m_sda = 1;
    tick(4);
    m_scl = 1;
    tick(8);
    m_sda = 0;
    tick(8);
    m_scl = 0;
    tick(4);
  endtask
  task automatic i2c_stop;
    m_sda = 0;
    tick(4);
    m_scl = 1;
    tick(8);
    m_sda = 1;
    tick(8);
  endtask
  task automatic check_reg(input logic [3:0] a, input logic [7:0] e);
    host_addr = a;
    @(negedge clk);
    chk($sformatf("host_rdata[%0d]", a), host_rdata, e);
  endtask
  initial begin
    logic ack, r, line9;
    logic [7:0] d;
    logic [3:0] a;
    vt[0] = '{8'hA0, 8'h03, {8'h22, 8'h11}, 2, 1'b1};
    vt[1] = '{8'h42, 8'h01, {8'h00, 8'h55}, 1, 1'b0};
    vt[2] = '{8'hA0, 8'h0F, {8'hC3, 8'h5A}, 2, 1'b1};
    vt[3] = '{8'hA0, 8'h12, {8'h00, 8'h77}, 1, 1'b1};
    vt[4] = '{8'hA0, 8'h07, {8'hAB, 8'h99}, 2, 1'b1};
    vt[5] = '{8'hA2, 8'h07, {8'h00, 8'hEE}, 1, 1'b0};
    foreach (model[i]) model[i] = '0;
    tick(3);
    chk("rst sda_oe", bus.sda_oe, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst host_rdata", host_rdata, 0);
    rst = 0;
    tick(5);
    for (int v = 0; v < NV; v++) begin
      strobes.delete();
      any_oe = 0;
      i2c_start();
      chk($sformatf("v%0d busy_on", v), busy, 1);
      send_byte(vt[v].dev, ack);
      chk($sformatf("v%0d dev_ack", v), ack, vt[v].ack);
      send_byte(vt[v].ra, ack);
      chk($sformatf("v%0d reg_ack", v), ack, vt[v].ack);
      for (int k = 0; k < vt[v].n; k++) begin
        send_byte(vt[v].d[k], ack);
        chk($sformatf("v%0d data%0d_ack", v, k), ack, vt[v].ack);
      end
      i2c_stop();
      chk($sformatf("v%0d busy_off", v), busy, 0);
      chk($sformatf("v%0d strobe_cnt", v), strobes.size(), vt[v].ack ? vt[v].n : 0);
      foreach (strobes[k]) begin
        a = 4'(vt[v].ra[3:0] + k);
        chk($sformatf("v%0d wr_addr%0d", v, k), strobes[k].a, a);
        chk($sformatf("v%0d wr_data%0d", v, k), strobes[k].d, vt[v].d[k]);
        chk($sformatf("v%0d wr_lat%0d", v, k), strobes[k].lat, 2);
        model[a] = vt[v].d[k];
      end
      if (!vt[v].ack) chk($sformatf("v%0d oe_quiet", v), any_oe, 0);
    end
    for (int i = 0; i < 16; i++) check_reg(4'(i), model[i]);
    // random read across the pointer wrap, ACK then NACK
    strobes.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    chk("rd dev_w_ack", ack, 1);
    send_byte(8'h0F, ack);
    chk("rd reg_ack", ack, 1);
    i2c_start();
    chk("rd busy_rs", busy, 1);
    send_byte(8'hA1, ack);
    chk("rd dev_r_ack", ack, 1);
    read_byte(1'b1, d, line9);
    chk("rd byte0", d, 8'h5A);
    chk("rd mack_line", line9, 0);
    read_byte(1'b0, d, line9);
    chk("rd byte1", d, 8'hC3);
    chk("rd nack_released", line9, 1);
    i2c_stop();
    chk("rd no_strobe", strobes.size(), 0);
    // partial byte cut off by STOP is discarded
    strobes.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    chk("ab reg_ack", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, r);
    i2c_stop();
    chk("ab no_strobe", strobes.size(), 0);
    check_reg(4'd2, model[2]);
    i2c_start();
    send_byte(8'hA1, ack);
    chk("ab dev_r_ack", ack, 1);
    read_byte(1'b0, d, line9);
    chk("ab readback", d, model[2]);
    i2c_stop();
    // reset while the target pulls SDA low in READ (reg7 = 0x99, bit6 = 0)
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h07, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    send_bit(1'b1, r);
    chk("rr bit7", r, 1);
    m_sda = 1;
    tick(4);
    m_scl = 1;
    tick(2);
    chk("rr driving", bus.sda_oe, 1);
    rst = 1;
    tick(1);
    chk("rr sda_oe", bus.sda_oe, 0);
    chk("rr busy", busy, 0);
    chk("rr wr_strobe", wr_strobe, 0);
    chk("rr wr_addr", wr_addr, 0);
    chk("rr wr_data", wr_data, 0);
    chk("rr host_rdata", host_rdata, 0);
    rst = 0;
    foreach (model[i]) model[i] = '0;
    tick(4);
    m_scl = 0;
    tick(4);
    strobes.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    chk("pr dev_ack", ack, 1);
    send_byte(8'h05, ack);
    chk("pr reg_ack", ack, 1);
    send_byte(8'h3C, ack);
    chk("pr data_ack", ack, 1);
    i2c_stop();
    chk("pr strobe_cnt", strobes.size(), 1);
    if (strobes.size() > 0) begin
      chk("pr wr_addr", strobes[0].a, 4'd5);
      chk("pr wr_data", strobes[0].d, 8'h3C);
    end
    check_reg(4'd5, 8'h3C);
    check_reg(4'd7, 8'h00);
    check_reg(4'hF, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
